// File: rtl/spi_inst_rx.sv
// SPI-style serial word receiver with a small output FIFO and sticky error flags.
// Optional accepted-word counter is enabled by defining SPI_INST_RX_WORD_COUNT_EN.
module spi_inst_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  spi_ss,
    input  logic                  spi_mosi,
    input  logic                  clr_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic                  frame_err_o,
    output logic [15:0]           word_count_o
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-2:0]   shift_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   shift_d;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W:0]          count_q;
    logic [PTR_W:0]          count_d;
    logic                    overflow_q;
    logic                    overflow_d;
    logic                    frame_err_q;
    logic                    frame_err_d;

    logic                    push_word;
    logic                    push_ok;
    logic                    drop;
    logic                    pop;
    logic                    full;
    logic                    frame_abort;

    // The final bit bypasses the shift register and goes straight into the FIFO word.
    assign shift_d     = {shift_q, spi_mosi};
    assign push_word   = (state_q == SHIFT) && !spi_ss && (bit_cnt_q == LAST_BIT);
    assign frame_abort = (state_q == SHIFT) && spi_ss && (bit_cnt_q != '0);
    assign full        = (count_q == FULL_CNT);
    assign pop         = (count_q != '0) && rx_ready_i;
    assign push_ok     = push_word && (!full || pop);
    assign drop        = push_word && full && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!spi_ss) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (spi_ss) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        shift_q <= shift_d[DATA_WIDTH-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q   <= GAP;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    bit_cnt_q <= '0;
                    if (spi_ss) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bit_cnt_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // A flag-setting event takes priority over a simultaneous clear.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        if (push_ok && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_i) begin
            overflow_d = 1'b0;
        end
        if (frame_abort) begin
            frame_err_d = 1'b1;
        end else if (clr_i) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_d;
        end
    end

    assign rx_valid_o  = (count_q != '0);
    assign rx_data_o   = rx_valid_o ? mem_q[rd_ptr_q] : '0;
    assign busy_o      = busy_q;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;

`ifdef SPI_INST_RX_WORD_COUNT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_cnt_q <= '0;
        end else if (push_ok && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_count_o = word_cnt_q;
`else
    assign word_count_o = 16'h0000;
`endif

endmodule

// File: doc/spi_inst_rx.md
SPI_INST_RX -- requirements
Module: spi_inst_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bits per received word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-word buffer entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port spi_ss  input  1  active-low frame select, synchronous to clk_i.
REQ-006 SHALL have port spi_mosi  input  1  serial data, MSB first, one bit per clk_i cycle.
REQ-007 SHALL have port clr_i  input  1  single-cycle pulse clearing sticky flags.
REQ-008 SHALL have port rx_data_o  output  DATA_WIDTH  head-of-FIFO word.
REQ-009 SHALL have port rx_valid_o  output  1  FIFO non-empty.
REQ-010 SHALL have port rx_ready_i  input  1  consumer accepts head word.
REQ-011 SHALL have port busy_o  output  1  high in SHIFT or GAP state.
REQ-012 SHALL have port overflow_o  output  1  sticky: word dropped, FIFO full.
REQ-013 SHALL have port frame_err_o  output  1  sticky: spi_ss rose mid-word.
REQ-014 SHALL have port word_count_o  output  16  accepted-word count.

Function
REQ-015 SHALL sample spi_ss and spi_mosi directly on rising clk_i, no synchronizer.
REQ-016 SHALL implement states IDLE, SHIFT, GAP.
REQ-017 IDLE: spi_ss low -> SHIFT, bit counter cleared; no bit sampled that cycle.
REQ-018 SHIFT: each cycle shift register <= {shift[DATA_WIDTH-2:0], spi_mosi}, bit counter +1.
REQ-019 SHIFT: on the DATA_WIDTH-th sampled bit, push the full word into FIFO, go to GAP.
REQ-020 GAP: lasts exactly one cycle, spi_mosi ignored; then SHIFT if spi_ss low, else IDLE.
REQ-021 spi_ss high in SHIFT with bit counter 1..DATA_WIDTH-1: discard partial word, set frame_err_o, go IDLE.
REQ-022 spi_ss high in SHIFT with bit counter 0: go IDLE, no error.
REQ-023 Push latency: rx_valid_o high the cycle after the final bit is sampled, when FIFO was empty.
REQ-024 Pop occurs when rx_valid_o && rx_ready_i; rx_data_o shows next entry the following cycle.
REQ-025 Push with FIFO full and no pop: word dropped, overflow_o set, contents unchanged.
REQ-026 Push and pop same cycle when full: both performed, no overflow.
REQ-027 Push and pop same cycle when empty: word goes into FIFO, no bypass; rx_valid_o high next cycle.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter distinguishes full from empty.
REQ-029 clr_i clears overflow_o and frame_err_o; a flag-setting event in the same cycle as clr_i wins.
REQ-030 rx_data_o SHALL hold a stable value while rx_valid_o && !rx_ready_i.

Reset
REQ-031 rst_ni low SHALL immediately force state IDLE, bit counter 0, shift register 0, FIFO empty.
REQ-032 During reset: rx_valid_o=0, rx_data_o=0, busy_o=0, overflow_o=0, frame_err_o=0, word_count_o=0.
REQ-033 Reset mid-word or mid-FIFO SHALL discard all partial and buffered data without raising flags.

Configuration
REQ-034 Macro SPI_INST_RX_WORD_COUNT_EN defined: word_count_o increments on each FIFO push that is not dropped, saturating at 16'hFFFF, cleared only by reset.
REQ-035 Macro SPI_INST_RX_WORD_COUNT_EN undefined: word_count_o tied to 0, no counter flops.

Verification
REQ-036 spi_ss low, shift 32'hDEADBEEF MSB first, rx_ready_i=1 -> rx_valid_o one cycle with rx_data_o=32'hDEADBEEF, word_count_o=1.
REQ-037 Back-to-back 32'h00000013, 32'h00500093 with one GAP bit (spi_mosi=1 in gap) -> both words popped in order, gap bit not captured.
REQ-038 rx_ready_i=0, send 5 words -> first 4 held in order, 5th dropped, overflow_o=1, word_count_o=4; clr_i -> overflow_o=0.
REQ-039 spi_ss rises after 17 bits -> frame_err_o=1, no push, next full word 32'hA5A5A5A5 received correctly.
REQ-040 FIFO full, final bit of word arrives same cycle rx_ready_i=1 -> no overflow, new word at tail, occupancy stays 4.
REQ-041 rst_ni pulsed low mid-word with 2 words buffered -> all outputs 0 immediately; next word after release received as first entry.
